// File: rtl/pc_sequencer.sv
// Program-counter sequencer: sequential, PC-relative, conditional and register-indirect next-PC selection.
// Optional return-address stack is compiled in when PC_SEQUENCER_RAS_EN is defined.
module pc_sequencer #(
  parameter int               WIDTH     = 64,
  parameter logic [WIDTH-1:0] RESET_PC  = '0,
  parameter int               IMM_SHIFT = 2,
  parameter int               RAS_DEPTH = 4
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             Stall,
  input  logic             Branch,
  input  logic             BranchNZ,
  input  logic             ALUZero,
  input  logic             Uncondbranch,
  input  logic             Link,
  input  logic             RegBranch,
  input  logic             Ret,
  input  logic [WIDTH-1:0] RegTarget,
  input  logic [WIDTH-1:0] SignExtImm,
  output logic [WIDTH-1:0] CurrentPC,
  output logic [WIDTH-1:0] NextPC,
  output logic             Taken,
  output logic             RasEmpty
);

  logic [WIDTH-1:0] current_pc_q;
  logic [WIDTH-1:0] current_pc_d;
  logic [WIDTH-1:0] seq_pc_s;
  logic [WIDTH-1:0] rel_pc_s;
  logic [WIDTH-1:0] next_pc_s;
  logic             taken_s;
  logic             cond_met_s;
  logic             ras_hit_s;
  logic [WIDTH-1:0] ras_top_s;

  assign seq_pc_s   = current_pc_q + WIDTH'(4);
  assign rel_pc_s   = current_pc_q + (SignExtImm << IMM_SHIFT);
  assign cond_met_s = BranchNZ ? ~ALUZero : ALUZero;

`ifdef PC_SEQUENCER_RAS_EN
  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] ras_q [RAS_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] wr_ptr_d;
  logic [PTR_W-1:0] top_ptr_s;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  logic             ras_empty_q;
  logic             ras_empty_d;
  logic             push_s;
  logic             pop_s;

  // wr_ptr always points at the slot the next push fills; a full stack overwrites the oldest entry.
  assign top_ptr_s = wr_ptr_q - PTR_W'(1);
  assign ras_top_s = ras_q[top_ptr_s];
  assign ras_hit_s = Ret & (count_q != CNT_W'(0));
  assign push_s    = ~Stall & Uncondbranch & Link & ~RegBranch;
  assign pop_s     = ~Stall & RegBranch & ras_hit_s;

  // Stack pointer and occupancy update for push/pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (push_s) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (count_q != CNT_W'(RAS_DEPTH)) begin
        count_d = count_q + CNT_W'(1);
      end else begin
        count_d = count_q;
      end
    end else if (pop_s) begin
      wr_ptr_d = top_ptr_s;
      count_d  = count_q - CNT_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
    end
    ras_empty_d = (count_d == CNT_W'(0));
  end

  // Stack control registers.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      wr_ptr_q    <= '0;
      count_q     <= '0;
      ras_empty_q <= 1'b1;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      ras_empty_q <= ras_empty_d;
    end
  end

  // Stack storage; contents are meaningless while count is zero, so no reset is needed.
  always_ff @(posedge CLK) begin
    if (!Reset && push_s) begin
      ras_q[wr_ptr_q] <= seq_pc_s;
    end
  end

  assign RasEmpty = ras_empty_q;
`else
  logic unused_ras_s;

  assign ras_hit_s    = 1'b0;
  assign ras_top_s    = '0;
  assign RasEmpty     = 1'b1;
  assign unused_ras_s = Link ^ Ret ^ RAS_DEPTH[0];
`endif

  // Next-PC priority: register branch, then unconditional, then conditional, else sequential.
  always_comb begin
    next_pc_s = seq_pc_s;
    taken_s   = 1'b0;
    if (RegBranch) begin
      taken_s   = 1'b1;
      next_pc_s = ras_hit_s ? ras_top_s : RegTarget;
    end else if (Uncondbranch) begin
      taken_s   = 1'b1;
      next_pc_s = rel_pc_s;
    end else if (Branch && cond_met_s) begin
      taken_s   = 1'b1;
      next_pc_s = rel_pc_s;
    end else begin
      taken_s   = 1'b0;
      next_pc_s = seq_pc_s;
    end
    current_pc_d = Stall ? current_pc_q : next_pc_s;
  end

  // PC register.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      current_pc_q <= RESET_PC;
    end else begin
      current_pc_q <= current_pc_d;
    end
  end

  assign CurrentPC = current_pc_q;
  assign NextPC    = next_pc_s;
  assign Taken     = taken_s;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: vector table, directed corner sequences and randomized
// traffic against a queue-based reference model. RAS expectations follow PC_SEQUENCER_RAS_EN.
module tb_pc_sequencer;

  localparam logic [63:0] RPC = 64'h400;
`ifdef PC_SEQUENCER_RAS_EN
  localparam bit RAS_EN = 1'b1;
`else
  localparam bit RAS_EN = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        Reset, Stall, Branch, BranchNZ, ALUZero, Uncondbranch, Link, RegBranch, Ret;
  logic [63:0] RegTarget, SignExtImm;
  logic [63:0] CurrentPC, NextPC;
  logic        Taken, RasEmpty;

  pc_sequencer #(.WIDTH(64), .RESET_PC(RPC), .IMM_SHIFT(2), .RAS_DEPTH(4)) dut (
    .CLK(CLK), .Reset(Reset), .Stall(Stall), .Branch(Branch), .BranchNZ(BranchNZ),
    .ALUZero(ALUZero), .Uncondbranch(Uncondbranch), .Link(Link), .RegBranch(RegBranch),
    .Ret(Ret), .RegTarget(RegTarget), .SignExtImm(SignExtImm), .CurrentPC(CurrentPC),
    .NextPC(NextPC), .Taken(Taken), .RasEmpty(RasEmpty)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  // Reference state: architectural PC and a return stack as a queue (back = most recent).
  logic [63:0] m_pc = RPC;
  logic [63:0] m_ras[$];

  typedef struct {
    logic        br, bnz, z, ub, lnk, rb, ret;
    logic [63:0] tgt, imm, exp_next;
    logic        exp_taken;
  } vec_t;

  vec_t vecs[12];

  function automatic vec_t mk(input logic br, input logic bnz, input logic z, input logic ub,
                              input logic lnk, input logic rb, input logic ret,
                              input logic [63:0] tgt, input logic [63:0] imm,
                              input logic [63:0] exp_next, input logic exp_taken);
    vec_t v;
    v.br = br; v.bnz = bnz; v.z = z; v.ub = ub; v.lnk = lnk; v.rb = rb; v.ret = ret;
    v.tgt = tgt; v.imm = imm; v.exp_next = exp_next; v.exp_taken = exp_taken;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic model_next(output logic [63:0] n, output logic t);
    logic [63:0] seq, rel;
    seq = m_pc + 64'd4;
    rel = m_pc + SignExtImm * 64'd4;
    t = 1'b1;
    if (RegBranch) begin
      if (RAS_EN && Ret && m_ras.size() > 0) n = m_ras[m_ras.size()-1];
      else n = RegTarget;
    end else if (Uncondbranch) begin
      n = rel;
    end else if (Branch && (BranchNZ ? !ALUZero : ALUZero)) begin
      n = rel;
    end else begin
      n = seq;
      t = 1'b0;
    end
  endtask

  task automatic model_step();
    logic [63:0] n;
    logic        t;
    model_next(n, t);
    if (Reset) begin
      m_pc = RPC;
      m_ras.delete();
    end else if (!Stall) begin
      if (RAS_EN) begin
        if (RegBranch && Ret && m_ras.size() > 0) begin
          void'(m_ras.pop_back());
        end else if (Uncondbranch && Link && !RegBranch) begin
          m_ras.push_back(m_pc + 64'd4);
          if (m_ras.size() > 4) void'(m_ras.pop_front());
        end
      end
      m_pc = n;
    end
  endtask

  task automatic clk_edge();
    @(posedge CLK);
    model_step();
    #1;
  endtask

  task automatic idle();
    Reset = 1'b0; Stall = 1'b0; Branch = 1'b0; BranchNZ = 1'b0; ALUZero = 1'b0;
    Uncondbranch = 1'b0; Link = 1'b0; RegBranch = 1'b0; Ret = 1'b0;
    RegTarget = 64'h0; SignExtImm = 64'h0;
  endtask

  task automatic do_reset();
    idle();
    Reset = 1'b1;
    clk_edge();
    Reset = 1'b0;
  endtask

  task automatic jump_to(input logic [63:0] addr);
    idle();
    RegBranch = 1'b1;
    RegTarget = addr;
    clk_edge();
    idle();
  endtask

  logic [63:0] exp_ret[5];
  logic [63:0] mn;
  logic        mt;

  initial begin
    idle();
    Reset = 1'b1;
    clk_edge();
    Reset = 1'b0;

    // Reset value and sequential stepping.
    chk("reset_pc", CurrentPC, 64'h400);
    chk("reset_ras_empty", {63'd0, RasEmpty}, 64'd1);
    for (int i = 1; i <= 3; i++) begin
      chk("idle_taken", {63'd0, Taken}, 64'd0);
      clk_edge();
      chk("idle_pc", CurrentPC, 64'h400 + 64'(4 * i));
    end

    // Vector table, applied with Stall=1 so CurrentPC remains 0x400.
    vecs[0]  = mk(0,0,0,0,0,0,0, 64'h0,          64'h0,                   64'h404,         1'b0);
    vecs[1]  = mk(1,0,1,0,0,0,0, 64'h0,          64'h1,                   64'h404,         1'b1);
    vecs[2]  = mk(1,0,0,0,0,0,0, 64'h0,          64'h5,                   64'h404,         1'b0);
    vecs[3]  = mk(1,1,0,0,0,0,0, 64'h0,          64'hFFFF_FFFF_FFFF_FFFC, 64'h3F0,         1'b1);
    vecs[4]  = mk(1,1,1,0,0,0,0, 64'h0,          64'h8,                   64'h404,         1'b0);
    vecs[5]  = mk(0,0,0,1,0,0,0, 64'h0,          64'h10,                  64'h440,         1'b1);
    vecs[6]  = mk(1,0,0,1,0,0,0, 64'h0,          64'hFFFF_FFFF_FFFF_FFFF, 64'h3FC,         1'b1);
    vecs[7]  = mk(0,0,0,0,0,1,0, 64'h1234_5678,  64'h10,                  64'h1234_5678,   1'b1);
    vecs[8]  = mk(1,0,1,1,0,1,0, 64'h2000,       64'h10,                  64'h2000,        1'b1);
    vecs[9]  = mk(0,0,0,1,1,0,0, 64'h0,          64'h2,                   64'h408,         1'b1);
    vecs[10] = mk(0,0,0,0,0,1,1, 64'hABC0,       64'h0,                   64'hABC0,        1'b1);
    vecs[11] = mk(0,0,0,1,0,0,0, 64'h0,          64'h3FFF_FFFF_FFFF_FFFF, 64'h3FC,         1'b1);
    do_reset();
    for (int i = 0; i < 12; i++) begin
      idle();
      Stall = 1'b1;
      Branch = vecs[i].br; BranchNZ = vecs[i].bnz; ALUZero = vecs[i].z;
      Uncondbranch = vecs[i].ub; Link = vecs[i].lnk; RegBranch = vecs[i].rb; Ret = vecs[i].ret;
      RegTarget = vecs[i].tgt; SignExtImm = vecs[i].imm;
      #1;
      chk($sformatf("vec%0d_next", i), NextPC, vecs[i].exp_next);
      chk($sformatf("vec%0d_taken", i), {63'd0, Taken}, {63'd0, vecs[i].exp_taken});
      clk_edge();
      chk($sformatf("vec%0d_stall_pc", i), CurrentPC, 64'h400);
      chk($sformatf("vec%0d_ras_empty", i), {63'd0, RasEmpty}, 64'd1);
    end

    // Conditional branch at 0x1000, then priority plus stall hold.
    jump_to(64'h1000);
    chk("jump_pc", CurrentPC, 64'h1000);
    Branch = 1'b1; BranchNZ = 1'b0; ALUZero = 1'b1; SignExtImm = 64'hFFFF_FFFF_FFFF_FFFE;
    #1;
    chk("cbz_taken_next", NextPC, 64'hFF8);
    chk("cbz_taken_flag", {63'd0, Taken}, 64'd1);
    ALUZero = 1'b0;
    #1;
    chk("cbz_not_next", NextPC, 64'h1004);
    chk("cbz_not_flag", {63'd0, Taken}, 64'd0);
    Uncondbranch = 1'b1; RegBranch = 1'b1; RegTarget = 64'h2000; Stall = 1'b1;
    #1;
    chk("prio_next", NextPC, 64'h2000);
    for (int i = 0; i < 2; i++) begin
      clk_edge();
      chk("stall_hold_pc", CurrentPC, 64'h1000);
    end
    Stall = 1'b0;
    clk_edge();
    chk("stall_release_pc", CurrentPC, 64'h2000);

    // Five BLs into a four-deep stack, then five returns.
    do_reset();
    for (int i = 1; i <= 5; i++) begin
      jump_to(64'(i * 256));
      Uncondbranch = 1'b1; Link = 1'b1; SignExtImm = 64'h40;
      clk_edge();
      chk("bl_pc", CurrentPC, 64'(i * 256 + 256));
      chk("bl_ras_empty", {63'd0, RasEmpty}, {63'd0, !RAS_EN});
    end
    if (RAS_EN) begin
      exp_ret[0] = 64'h504; exp_ret[1] = 64'h404; exp_ret[2] = 64'h304; exp_ret[3] = 64'h204;
    end else begin
      exp_ret[0] = 64'h7000; exp_ret[1] = 64'h7000; exp_ret[2] = 64'h7000; exp_ret[3] = 64'h7000;
    end
    exp_ret[4] = 64'h7000;
    idle();
    RegBranch = 1'b1; Ret = 1'b1; RegTarget = 64'h7000;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk($sformatf("ret%0d_next", k), NextPC, exp_ret[k]);
      clk_edge();
      chk($sformatf("ret%0d_pc", k), CurrentPC, exp_ret[k]);
      chk($sformatf("ret%0d_ras_empty", k), {63'd0, RasEmpty}, {63'd0, (!RAS_EN) || (k >= 3)});
    end

    // Reset on the same edge as a BL, with a non-empty stack beforehand.
    jump_to(64'h80);
    Uncondbranch = 1'b1; Link = 1'b1; SignExtImm = 64'h20;
    clk_edge();
    chk("pre_reset_pc", CurrentPC, 64'h100);
    Reset = 1'b1; Stall = 1'b1;
    clk_edge();
    chk("reset_bl_pc", CurrentPC, RPC);
    chk("reset_bl_ras_empty", {63'd0, RasEmpty}, 64'd1);
    idle();
    RegBranch = 1'b1; Ret = 1'b1; RegTarget = 64'h9000;
    #1;
    chk("reset_ret_next", NextPC, 64'h9000);

    // Offset shift wraps past the top of the address space.
    jump_to(64'h8);
    Uncondbranch = 1'b1; SignExtImm = 64'h3FFF_FFFF_FFFF_FFFF;
    #1;
    chk("wrap_next", NextPC, 64'h4);
    chk("wrap_taken", {63'd0, Taken}, 64'd1);

    // Randomized traffic against the reference model.
    do_reset();
    for (int i = 0; i < 400; i++) begin
      Reset        = ($urandom_range(0, 49) == 0);
      Stall        = ($urandom_range(0, 3) == 0);
      Branch       = 1'($urandom);
      BranchNZ     = 1'($urandom);
      ALUZero      = 1'($urandom);
      Uncondbranch = 1'($urandom);
      Link         = 1'($urandom);
      RegBranch    = ($urandom_range(0, 4) == 0);
      Ret          = 1'($urandom);
      RegTarget    = {$urandom, $urandom};
      if ($urandom_range(0, 3) != 0) SignExtImm = 64'(int'($urandom_range(0, 64)) - 32);
      else SignExtImm = {$urandom, $urandom};
      #1;
      model_next(mn, mt);
      chk("rand_next", NextPC, mn);
      chk("rand_taken", {63'd0, Taken}, {63'd0, mt});
      clk_edge();
      chk("rand_pc", CurrentPC, m_pc);
      chk("rand_ras_empty", {63'd0, RasEmpty}, {63'd0, m_ras.size() == 0});
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 SHALL have parameter WIDTH, default 64, giving the PC and immediate width in bits.
REQ-002 SHALL have parameter RESET_PC, default 0, giving the PC value loaded on reset.
REQ-003 SHALL have parameter IMM_SHIFT, default 2, giving the left shift applied to the branch immediate.
REQ-004 SHALL have parameter RAS_DEPTH, default 4 (power of two, at least 2), giving the return-address stack entries.
REQ-005 SHALL use one clock and a synchronous, active-high reset, with ports as follows:
- CLK  in  1  clock; all state updates on the rising edge.
- Reset  in  1  synchronous, active-high reset.
- Stall  in  1  holds the PC and the RAS.
- Branch  in  1  conditional branch.
- BranchNZ  in  1  with Branch set, takes the branch when ALUZero=0 (CBNZ); otherwise the branch is taken when ALUZero=1 (CBZ).
- ALUZero  in  1  ALU zero flag.
- Uncondbranch  in  1  PC-relative unconditional branch.
- Link  in  1  with Uncondbranch set, performs BL: pushes the return address.
- RegBranch  in  1  register-indirect branch (BR).
- Ret  in  1  with RegBranch set, marks the branch as a return.
- RegTarget  in  WIDTH  register target address.
- SignExtImm  in  WIDTH  sign-extended branch offset.
- CurrentPC  out  WIDTH  registered PC.
- NextPC  out  WIDTH  combinational PC to be loaded on the next edge.
- Taken  out  1  combinational; 1 when NextPC is not the sequential address.
- RasEmpty  out  1  registered; the RAS holds no entries.

Function
REQ-006 SHALL compute SeqPC = CurrentPC + 4 and RelPC = CurrentPC + (SignExtImm << IMM_SHIFT), both truncated to WIDTH bits (wrap-around, no overflow flag).
REQ-007 SHALL select NextPC with the following priority:
- RegBranch selects RegTarget, or the RAS top per REQ-014.
- Otherwise Uncondbranch selects RelPC.
- Otherwise Branch with its condition met selects RelPC.
- Otherwise SeqPC.
REQ-008 SHALL assert Taken exactly when NextPC is selected from a source other than SeqPC; Taken SHALL also assert when the target value happens to equal SeqPC.
REQ-009 SHALL load CurrentPC <= NextPC on every rising edge with Reset=0 and Stall=0.
REQ-010 SHALL hold CurrentPC and all RAS state when Stall=1; NextPC and Taken SHALL still reflect the current inputs.
REQ-011 SHALL ignore Link unless Uncondbranch=1 and RegBranch=0, and SHALL ignore Ret unless RegBranch=1.
REQ-012 SHALL give CurrentPC-to-NextPC a latency of zero cycles (combinational) and NextPC-to-CurrentPC a latency of one cycle.

Reset
REQ-013 SHALL, on a rising edge with Reset=1, set CurrentPC=RESET_PC, clear the RAS (count=0, RasEmpty=1) and discard any concurrent Stall, Link or Ret; Reset has priority over all other inputs, including mid-branch.

Configuration
REQ-014 SHALL compile the return-address stack only when macro PC_SEQUENCER_RAS_EN is defined, with the following behaviour:
- Push on a BL edge: stores SeqPC.
- Pop on a Ret edge: when the RAS is non-empty, NextPC = top entry instead of RegTarget.
- Pop on an empty RAS: falls back to RegTarget, count stays 0.
- Push when count=RAS_DEPTH: overwrites the oldest entry circularly, count stays RAS_DEPTH.
- RasEmpty updates one edge after a push or pop.
REQ-015 SHALL, without PC_SEQUENCER_RAS_EN, contain no RAS storage, treat Ret as plain RegBranch, ignore Link, and tie RasEmpty to 1.

Verification
REQ-016 SHALL check the following directed scenarios:
- Reset with RESET_PC=0x400, then 3 idle edges -> CurrentPC 0x400, 0x404, 0x408, 0x40C; Taken=0.
- CurrentPC=0x1000, Branch=1, BranchNZ=0, ALUZero=1, SignExtImm=-2 -> NextPC=0xFF8 and Taken=1; with ALUZero=0 instead -> NextPC=0x1004 and Taken=0.
- RegBranch=1, Uncondbranch=1, Branch=1 all asserted with RegTarget=0x2000 -> NextPC=0x2000; with Stall=1 for 2 edges -> CurrentPC unchanged, then 0x2000 after Stall drops.
- RAS enabled, DEPTH=4: BL from 0x100, 0x200, 0x300, 0x400, 0x500, then 5 RETs -> NextPC 0x504, 0x404, 0x304, 0x204, then RegTarget on the 5th RET; RasEmpty=1 after the 4th pop.
- Reset asserted on the same edge as a BL at CurrentPC=0x100 -> CurrentPC=RESET_PC, RasEmpty=1; a following RET uses RegTarget.
- SignExtImm=0x3FFF_FFFF_FFFF_FFFF at CurrentPC=0x8 with Uncondbranch=1 -> NextPC=0x4 (wrap), Taken=1.
